// File: rtl/cc_register_pkg.sv
// Shared definitions for the condition-code producer: widths, icodes, ALU functions,
// CC bit positions, reset value and FSM encodings.
package cc_register_pkg;

  localparam int DATA_WID = 64;

  localparam logic [3:0] ICODE_OP    = 4'h6;
  localparam logic [3:0] ICODE_PUSHQ = 4'hA;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;

  localparam logic [3:0] CC_RESET = 4'b0001;

  typedef enum logic {
    CC_RUN    = 1'b0,
    CC_FROZEN = 1'b1
  } cc_state_e;

  // Place the three flags at their CC bit positions; the spare bit stays 0.
  function automatic logic [3:0] cc_pack(input logic zf, input logic sf, input logic of);
    logic [3:0] cc;
    cc        = 4'b0000;
    cc[CC_ZF] = zf;
    cc[CC_SF] = sf;
    cc[CC_OF] = of;
    return cc;
  endfunction

endpackage

// File: rtl/cc_register_if.sv
// Execute-stage to CC-register bundle: ALU operands/result, write qualifiers and the
// registered condition codes returned to the condition evaluator.
interface cc_register_if #(
  parameter int DATA_WID = cc_register_pkg::DATA_WID
);

  logic                e_valid;
  logic [3:0]          e_icode;
  logic [1:0]          e_alufun;
  logic [DATA_WID-1:0] aluA;
  logic [DATA_WID-1:0] aluB;
  logic [DATA_WID-1:0] valE;
  logic                stall;
  logic                m_exc;
  logic                w_exc;
  logic [3:0]          CC;
  logic                cc_upd;
  logic                frozen;

  modport master (
    output e_valid, e_icode, e_alufun, aluA, aluB, valE, stall, m_exc, w_exc,
    input  CC, cc_upd, frozen
  );

  modport slave (
    input  e_valid, e_icode, e_alufun, aluA, aluB, valE, stall, m_exc, w_exc,
    output CC, cc_upd, frozen
  );

endinterface

// File: rtl/cc_flag_gen.sv
// Combinational ZF/SF/OF generation from ALU operand signs, result and function select.
// Only operand sign bits matter for overflow, so only those are taken as inputs.
module cc_flag_gen
  import cc_register_pkg::*;
#(
  parameter int DATA_WID = cc_register_pkg::DATA_WID
) (
  input  logic                a_sign,
  input  logic                b_sign,
  input  logic [DATA_WID-1:0] valE,
  input  logic [1:0]          alufun,
  output logic [3:0]          flags
);

  logic zf_s;
  logic sf_s;
  logic of_s;

  // Flag derivation; subtract is B - A so overflow compares the result against B's sign.
  always_comb begin
    zf_s = (valE == {DATA_WID{1'b0}});
    sf_s = valE[DATA_WID-1];
    of_s = 1'b0;
    case (alu_fun_e'(alufun))
      ALU_ADD: of_s = (a_sign == b_sign) & (valE[DATA_WID-1] != a_sign);
      ALU_SUB: of_s = (a_sign != b_sign) & (valE[DATA_WID-1] != b_sign);
      ALU_AND: of_s = 1'b0;
      ALU_XOR: of_s = 1'b0;
      default: of_s = 1'b0;
    endcase
    flags = cc_pack(zf_s, sf_s, of_s);
  end

endmodule

// File: rtl/cc_register.sv
// Condition-code register: flag generation, write qualification, CC flop and a
// RUN/FROZEN FSM that locks CC once an exception reaches memory or writeback.
module cc_register #(
  parameter int         DATA_WID = cc_register_pkg::DATA_WID,
  parameter logic [3:0] CC_RESET = cc_register_pkg::CC_RESET
) (
  input logic         clk,
  input logic         rst,
  cc_register_if.slave cc_bus
);

  import cc_register_pkg::*;

  cc_state_e  state_r;
  cc_state_e  state_nxt_s;
  logic       exc_s;
  logic       we_s;
  logic [3:0] flags_s;
  logic [3:0] cc_r;
  logic       cc_upd_r;
  logic       frozen_r;

  cc_flag_gen #(
    .DATA_WID (DATA_WID)
  ) u_flag_gen (
    .a_sign (cc_bus.aluA[DATA_WID-1]),
    .b_sign (cc_bus.aluB[DATA_WID-1]),
    .valE   (cc_bus.valE),
    .alufun (cc_bus.e_alufun),
    .flags  (flags_s)
  );

  // Write enable and next-state; an exception blocks the write on the same edge it freezes.
  always_comb begin
    exc_s       = cc_bus.m_exc | cc_bus.w_exc;
    we_s        = (state_r == CC_RUN) & cc_bus.e_valid & (cc_bus.e_icode == ICODE_OP)
                  & ~cc_bus.stall & ~exc_s;
    state_nxt_s = state_r;
    case (state_r)
      CC_RUN: begin
        if (exc_s) begin
          state_nxt_s = CC_FROZEN;
        end else begin
          state_nxt_s = CC_RUN;
        end
      end
      CC_FROZEN: state_nxt_s = CC_FROZEN;
      default:   state_nxt_s = CC_FROZEN;
    endcase
  end

  // State, CC and status flops; reset overrides any freeze or concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= CC_RUN;
      cc_r     <= CC_RESET;
      cc_upd_r <= 1'b0;
      frozen_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      frozen_r <= (state_nxt_s == CC_FROZEN);
      cc_upd_r <= we_s;
      if (we_s) begin
        cc_r <= flags_s;
      end
    end
  end

  assign cc_bus.CC     = cc_r;
  assign cc_bus.cc_upd = cc_upd_r;
  assign cc_bus.frozen = frozen_r;

endmodule

// File: tb/tb_cc_register.sv
// Scoreboard bench for cc_register: each directed vector pushes its hand-computed
// post-edge CC/cc_upd/frozen; a monitor pops and compares one entry per clock.
module tb_cc_register;

  import cc_register_pkg::*;

  typedef struct {
    logic [3:0] cc;
    logic       upd;
    logic       frz;
    string      name;
  } exp_t;

  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ZERO = 64'h0000_0000_0000_0000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  cc_register_if #(.DATA_WID(64)) bus ();

  cc_register #(
    .DATA_WID (64),
    .CC_RESET (4'b0001)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cc_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge and queue the result expected after the next rising edge.
  task automatic drv(input logic r, input logic v, input logic [3:0] ic, input logic [1:0] fn,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] e,
                     input logic st, input logic me, input logic we,
                     input logic [3:0] xcc, input logic xu, input logic xf, input string nm);
    exp_t x;
    @(negedge clk);
    rst          = r;
    bus.e_valid  = v;
    bus.e_icode  = ic;
    bus.e_alufun = fn;
    bus.aluA     = a;
    bus.aluB     = b;
    bus.valE     = e;
    bus.stall    = st;
    bus.m_exc    = me;
    bus.w_exc    = we;
    x.cc   = xcc;
    x.upd  = xu;
    x.frz  = xf;
    x.name = nm;
    sb_q.push_back(x);
  endtask

  // Monitor: compare DUT outputs just after each rising edge against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        checks++;
        if (bus.CC !== x.cc || bus.cc_upd !== x.upd || bus.frozen !== x.frz) begin
          errors++;
          $display("FAIL %s: got CC=%b cc_upd=%b frozen=%b, expected CC=%b cc_upd=%b frozen=%b",
                   x.name, bus.CC, bus.cc_upd, bus.frozen, x.cc, x.upd, x.frz);
        end
      end
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.e_valid  = 1'b0;
    bus.e_icode  = 4'h0;
    bus.e_alufun = 2'd0;
    bus.aluA     = ZERO;
    bus.aluB     = ZERO;
    bus.valE     = ZERO;
    bus.stall    = 1'b0;
    bus.m_exc    = 1'b0;
    bus.w_exc    = 1'b0;

    // Reset held for two cycles
    drv(1'b1, 1'b0, 4'h0, ALU_ADD, ZERO, ZERO, ZERO, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, "reset0");
    drv(1'b1, 1'b0, 4'h0, ALU_ADD, ZERO, ZERO, ZERO, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, "reset1");

    // Sub overflow: 0x8000.. - 1
    drv(1'b0, 1'b1, ICODE_OP, ALU_SUB, 64'd1, MINV, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0,
        4'b0100, 1'b1, 1'b0, "sub_ovf");
    drv(1'b0, 1'b0, 4'h0, ALU_ADD, ZERO, ZERO, ZERO, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, "sub_hold");

    // Add to zero with overflow, then And with negative result
    drv(1'b0, 1'b1, ICODE_OP, ALU_ADD, MINV, MINV, ZERO, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b1, 1'b0, "add_zero_ovf");
    drv(1'b0, 1'b1, ICODE_OP, ALU_AND, 64'hF000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'hF000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, "and_neg");

    // Gating: stall, bubble, push using Sub
    drv(1'b0, 1'b1, ICODE_OP, ALU_ADD, ZERO, ZERO, ZERO, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, "stall");
    drv(1'b0, 1'b0, ICODE_OP, ALU_ADD, ZERO, ZERO, ZERO, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, "bubble");
    drv(1'b0, 1'b1, ICODE_PUSHQ, ALU_SUB, 64'd8, 64'd8, ZERO, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, "push_sub");

    // Exception freezes CC; later OPs are ignored; reset with a coincident OP recovers
    drv(1'b0, 1'b1, ICODE_OP, ALU_ADD, ZERO, ZERO, ZERO, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, "exc_freeze");
    drv(1'b0, 1'b1, ICODE_OP, ALU_ADD, ZERO, ZERO, ZERO, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, "frozen_op1");
    drv(1'b0, 1'b1, ICODE_OP, ALU_SUB, 64'd1, MINV, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0,
        4'b0010, 1'b0, 1'b1, "frozen_op2");
    drv(1'b1, 1'b1, ICODE_OP, ALU_ADD, ZERO, ZERO, ZERO, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, "reset_unfreeze");
    drv(1'b0, 1'b1, ICODE_OP, ALU_XOR, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
        64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, "xor_after_reset");

    // Back-to-back OPs: 2+3=5, then 2-5=-3
    drv(1'b0, 1'b1, ICODE_OP, ALU_ADD, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, "b2b_pos");
    drv(1'b0, 1'b1, ICODE_OP, ALU_SUB, 64'd5, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0,
        4'b0010, 1'b1, 1'b0, "b2b_neg");
    drv(1'b0, 1'b0, 4'h0, ALU_ADD, ZERO, ZERO, ZERO, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, "b2b_idle");

    // Writeback exception with stall: no write, still freezes; then reset
    drv(1'b0, 1'b1, ICODE_OP, ALU_ADD, ZERO, ZERO, ZERO, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, "wexc_stall");
    drv(1'b0, 1'b1, ICODE_OP, ALU_ADD, ZERO, ZERO, ZERO, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, "wexc_hold");
    drv(1'b1, 1'b0, 4'h0, ALU_ADD, ZERO, ZERO, ZERO, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, "final_reset");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
